instr_mem: RTL and testbench

Parametrised, synchronous instruction memory for the core's fetch path, replacing the fixed 8-bit-address / 17-bit-word combinational program ROM. It is loaded at run time over a write port and served to the fetch stage through a valid/ready request/response handshake with one-cycle read latency. Unwritten words read as the all-zero NOP, matching the chip-select-low behaviour fetch already expects. A sticky lock freezes the contents once boot loading is complete.

---
 rtl/instr_mem_pkg.sv | 14 +
 rtl/instr_mem_array.sv | 56 +++++
 rtl/instr_mem.sv | 90 +++++++++
 tb/tb_instr_mem.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared types and defaults for the fetch-path instruction memory
package instr_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  localparam int DEF_INSTR_W = 17;
  localparam int DEF_ADDR_W  = 8;

  localparam logic [DEF_INSTR_W-1:0] INSTR_NOP = '0;

endpackage

// File: rtl/instr_mem_array.sv
// rtl/instr_mem_array.sv - word storage with per-word written bits and a registered read port
module instr_mem_array
  import instr_mem_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = 1 << DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic               re,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [INSTR_W-1:0] rd_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]   written;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic               wr_ok;
  logic               rd_ok;

  assign wr_idx = wr_addr[IDX_W-1:0];
  assign rd_idx = rd_addr[IDX_W-1:0];
  assign wr_ok  = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_ok  = ({1'b0, rd_addr} < DEPTH_L);

  // Storage itself is left unreset so it maps onto a RAM; written bits mask stale contents.
  always_ff @(posedge clk) begin
    if (we && wr_ok) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written <= '0;
    end else if (we && wr_ok) begin
      written[wr_idx] <= 1'b1;
    end
  end

  // Read register only loads on an accepted fetch, which keeps a stalled response stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= INSTR_W'(INSTR_NOP);
    end else if (re) begin
      rd_data <= (rd_ok && written[rd_idx]) ? mem[rd_idx] : INSTR_W'(INSTR_NOP);
    end
  end

endmodule

// File: rtl/instr_mem.sv
// rtl/instr_mem.sv - run-time loadable instruction memory with fetch handshake and sticky lock
module instr_mem
  import instr_mem_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = 1 << DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cs,
  input  logic               req_valid,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               req_ready,
  output logic               rsp_valid,
  output logic [INSTR_W-1:0] rsp_instr,
  output logic               rsp_err,
  input  logic               rsp_ready,
  input  logic               ld_valid,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic [INSTR_W-1:0] ld_data,
  output logic               ld_ready,
  input  logic               lock,
  output logic               locked,
  output logic               ld_err
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_t state, next_state;
  logic   req_fire;
  logic   ld_fire;
  logic   req_in_range;
  logic   ld_in_range;

  assign req_in_range = ({1'b0, req_addr} < DEPTH_L);
  assign ld_in_range  = ({1'b0, ld_addr} < DEPTH_L);

  // Loads take priority over fetches so a boot loader is never starved.
  assign ld_ready  = cs & ~locked;
  assign ld_fire   = ld_valid & ld_ready;
  assign req_ready = cs & ~ld_fire & ((state == IDLE) | rsp_ready);
  assign req_fire  = req_valid & req_ready;
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req_fire) next_state = RESP;
      RESP: begin
        if (req_fire)       next_state = RESP;
        else if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err <= 1'b0;
      locked  <= 1'b0;
      ld_err  <= 1'b0;
    end else begin
      if (req_fire) rsp_err <= ~req_in_range;
      if (lock) locked <= 1'b1;
      if (ld_fire && !ld_in_range) ld_err <= 1'b1;
    end
  end

  instr_mem_array #(
    .INSTR_W(INSTR_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (ld_fire),
    .wr_addr(ld_addr),
    .wr_data(ld_data),
    .re     (req_fire),
    .rd_addr(req_addr),
    .rd_data(rsp_instr)
  );

endmodule

// File: tb/tb_instr_mem.sv
// tb/tb_instr_mem.sv - vector table plus response scoreboard for instr_mem (DEPTH = 34)
module tb_instr_mem;

  localparam int IW = 17;
  localparam int AW = 8;
  localparam int DP = 34;

  logic clk = 1'b0;
  logic rst_n, cs, req_valid, req_ready, rsp_valid, rsp_err, rsp_ready;
  logic ld_valid, ld_ready, lock, locked, ld_err;
  logic [AW-1:0] req_addr, ld_addr;
  logic [IW-1:0] rsp_instr, ld_data;

  instr_mem #(.INSTR_W(IW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_instr(rsp_instr), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .lock(lock), .locked(locked), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          cs;
    logic          lock;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [IW-1:0] ld_data;
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic          rsp_ready;
    logic [IW-1:0] exp_instr;
    logic          exp_err;
  } vec_t;

  typedef struct {
    logic [IW-1:0] instr;
    logic          err;
  } rsp_t;

  rsp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic m_pend = 1'b0, m_locked = 1'b0, m_lderr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t ld(input logic [AW-1:0] a, input logic [IW-1:0] d);
    vec_t v = '{1'b1, 1'b0, 1'b1, a, d, 1'b0, '0, 1'b1, '0, 1'b0};
    return v;
  endfunction

  function automatic vec_t rq(input logic [AW-1:0] a, input logic [IW-1:0] e, input logic er);
    vec_t v = '{1'b1, 1'b0, 1'b0, '0, '0, 1'b1, a, 1'b1, e, er};
    return v;
  endfunction

  function automatic vec_t idle();
    vec_t v = '{1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, '0, 1'b0};
    return v;
  endfunction

  // Drive one cycle, check handshake/status and scoreboard at the falling edge, then advance.
  task automatic apply(input vec_t v);
    logic e_ldr, e_rqr;
    rsp_t r;
    cs = v.cs; lock = v.lock; ld_valid = v.ld_valid; ld_addr = v.ld_addr; ld_data = v.ld_data;
    req_valid = v.req_valid; req_addr = v.req_addr; rsp_ready = v.rsp_ready;
    @(negedge clk);
    e_ldr = v.cs & ~m_locked;
    e_rqr = v.cs & ~(v.ld_valid & e_ldr) & (~m_pend | v.rsp_ready);
    chk("ld_ready", ld_ready, e_ldr);
    chk("req_ready", req_ready, e_rqr);
    chk("rsp_valid", rsp_valid, m_pend);
    chk("locked", locked, m_locked);
    chk("ld_err", ld_err, m_lderr);
    if (m_pend && v.rsp_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        r = sb.pop_front();
        chk("rsp_instr", rsp_instr, r.instr);
        chk("rsp_err", rsp_err, r.err);
      end
    end
    if (v.req_valid && e_rqr) begin
      sb.push_back('{v.exp_instr, v.exp_err});
      m_pend = 1'b1;
    end else if (v.rsp_ready) begin
      m_pend = 1'b0;
    end
    if (v.lock) m_locked = 1'b1;
    if (v.ld_valid && e_ldr && v.ld_addr >= DP) m_lderr = 1'b1;
    @(posedge clk); #1;
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    rst_n = 1'b0; cs = 1'b1; lock = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_instr", rsp_instr, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_locked", locked, 0);
    chk("rst_ld_err", ld_err, 0);
    chk("rst_req_ready_cs1", req_ready, 1);
    chk("rst_ld_ready_cs1", ld_ready, 1);
    cs = 1'b0; #1;
    chk("rst_req_ready_cs0", req_ready, 0);
    chk("rst_ld_ready_cs0", ld_ready, 0);
    cs = 1'b1;
    @(posedge clk); #1; rst_n = 1'b1;

    tbl.push_back(rq(8'h05, 17'h0, 1'b0));
    tbl.push_back(ld(8'h01, 17'h08004));
    tbl.push_back(rq(8'h01, 17'h08004, 1'b0));
    for (int a = 0; a < 4; a++) tbl.push_back(rq(8'(a), (a == 1) ? 17'h08004 : 17'h0, 1'b0));
    tbl.push_back(ld(8'h03, 17'h1FFFF));
    tbl.push_back(ld(8'h21, 17'h12345));
    tbl.push_back(rq(8'h21, 17'h12345, 1'b0));
    tbl.push_back(rq(8'h22, 17'h0, 1'b1));
    tbl.push_back(rq(8'h40, 17'h0, 1'b1));
    tbl.push_back(rq(8'h03, 17'h1FFFF, 1'b0));
    tbl.push_back(rq(8'hFF, 17'h0, 1'b1));
    v = ld(8'h02, 17'h0BEEF); v.req_valid = 1'b1; v.req_addr = 8'h01; v.cs = 1'b0;
    tbl.push_back(v);
    tbl.push_back(rq(8'h02, 17'h0, 1'b0));
    tbl.push_back(idle());
    foreach (tbl[i]) apply(tbl[i]);

    // Stalled response stays stable and blocks new fetches; release accepts in the same cycle.
    apply(rq(8'h01, 17'h08004, 1'b0));
    for (int i = 0; i < 3; i++) begin
      v = rq(8'h03, 17'h1FFFF, 1'b0); v.rsp_ready = 1'b0;
      apply(v);
      chk("stall_instr", rsp_instr, 17'h08004);
      chk("stall_valid", rsp_valid, 1);
    end
    apply(rq(8'h03, 17'h1FFFF, 1'b0));
    apply(idle());

    // Out-of-range loads only set ld_err; aliasing low bits must not reach word 0.
    apply(ld(8'h40, 17'h1ABCD));
    apply(ld(8'h22, 17'h15A5A));
    chk("ld_err_set", ld_err, 1);
    apply(rq(8'h00, 17'h0, 1'b0));
    apply(idle());

    // Load and fetch together: load first, fetch next cycle sees the new word.
    v = ld(8'h04, 17'h00777); v.req_valid = 1'b1; v.req_addr = 8'h04;
    apply(v);
    apply(rq(8'h04, 17'h00777, 1'b0));
    apply(idle());

    // Lock: same-cycle load still lands, later loads are refused and do not block fetches.
    apply(ld(8'h02, 17'h00222));
    v = ld(8'h05, 17'h0AAAA); v.lock = 1'b1;
    apply(v);
    chk("locked_set", locked, 1);
    v = ld(8'h02, 17'h15555); v.req_valid = 1'b1; v.req_addr = 8'h02; v.exp_instr = 17'h00222;
    apply(v);
    apply(rq(8'h05, 17'h0AAAA, 1'b0));
    apply(idle());

    // Reset while a response is held drops it at once and clears written bits.
    apply(rq(8'h02, 17'h00222, 1'b0));
    rsp_ready = 1'b0; req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_rsp_instr", rsp_instr, 0);
    chk("arst_locked", locked, 0);
    chk("arst_ld_err", ld_err, 0);
    sb.delete(); m_pend = 1'b0; m_locked = 1'b0; m_lderr = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    apply(rq(8'h02, 17'h0, 1'b0));
    apply(idle());
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
